// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame arbiter: sizes, widths and FSM states.
package lcd_pkg;

   localparam int N_SRC    = 4;
   localparam int RGB565_W = 16;
   localparam int SEL_W    = 2;
   localparam int HOLD_W   = 8;
   localparam int IDLE_W   = 8;

   typedef enum logic [1:0] {
      DEFAULT = 2'd0,
      ARM     = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit encoder: returns the index of the top asserted bit and a valid flag.
module prio_enc #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Later (higher) bits overwrite earlier ones, so the top set bit wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            idx_o   = IDX_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Chooses which pixel source drives the LCD, switching only on frame boundaries
// so that no frame ever mixes two sources. Source 0 is the fallback display.
module lcd_frame_arbiter #(
   parameter int N_SRC          = 4,
   parameter int MIN_HOLD       = 2,
   parameter int TIMEOUT_FRAMES = 200
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 sof,
   input  logic [N_SRC-1:0]                     req,
   input  logic [lcd_pkg::RGB565_W*N_SRC-1:0]   src_data,
   output logic [N_SRC-1:0]                     gnt,
   output logic [lcd_pkg::SEL_W-1:0]            sel,
   output logic [lcd_pkg::RGB565_W-1:0]         pix_data,
   output logic                                 switching,
   output logic                                 idle_timeout
);

   import lcd_pkg::*;

   localparam logic [N_SRC-1:0]  ONE_HOT0    = {{(N_SRC-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(MIN_HOLD);
   localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(TIMEOUT_FRAMES);

   arb_state_e         state_q;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   pend_q;
   logic [N_SRC-1:0]   gnt_q;
   logic [HOLD_W-1:0]  hold_q;
   logic [HOLD_W-1:0]  hold_d;
   logic [IDLE_W-1:0]  idle_q;
   logic [IDLE_W-1:0]  idle_d;
   logic               switching_q;
   logic               timeout_q;

   logic [N_SRC-1:0]   reqMasked;
   logic [SEL_W-1:0]   winIdx;
   logic               winValid;

   // Source 0 never requests; it is what shows when nobody else wants the screen.
   assign reqMasked = req & ~ONE_HOT0;

   prio_enc #(
      .N     (N_SRC),
      .IDX_W (SEL_W)
   ) u_prio_enc (
      .vec_i   (reqMasked),
      .idx_o   (winIdx),
      .valid_o (winValid)
   );

   // Saturating next values for the per-grant hold counter and the idle frame counter.
   always_comb begin
      hold_d = (hold_q >= HOLD_MAX) ? hold_q : hold_q + 1'b1;
      idle_d = (idle_q == TIMEOUT_VAL) ? idle_q : idle_q + 1'b1;
   end

   // Arbitration FSM; every output is a register so sel/gnt only move on the chosen edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DEFAULT;
         sel_q       <= '0;
         pend_q      <= '0;
         gnt_q       <= ONE_HOT0;
         hold_q      <= '0;
         idle_q      <= '0;
         switching_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         if (state_q != DEFAULT) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
         end
         case (state_q)
            DEFAULT: begin
               if (winValid) begin
                  pend_q      <= winIdx;
                  state_q     <= ARM;
                  switching_q <= 1'b1;
                  idle_q      <= '0;
                  timeout_q   <= 1'b0;
               end else if (sof) begin
                  idle_q <= idle_d;
                  if (idle_d == TIMEOUT_VAL) begin
                     timeout_q <= 1'b1;
                  end
               end
            end
            ARM: begin
               if (!winValid) begin
                  state_q     <= DEFAULT;
                  switching_q <= 1'b0;
               end else if (winIdx != pend_q) begin
                  pend_q <= winIdx;
               end else if (sof) begin
                  sel_q       <= pend_q;
                  gnt_q       <= ONE_HOT0 << pend_q;
                  hold_q      <= '0;
                  state_q     <= GRANT;
                  switching_q <= 1'b0;
               end
            end
            GRANT: begin
               if (sof) begin
                  hold_q <= hold_d;
               end
               if (!req[sel_q] ||
                   (winValid && (winIdx > sel_q) && (hold_q >= HOLD_MAX))) begin
                  state_q     <= RELEASE;
                  switching_q <= 1'b1;
               end
            end
            RELEASE: begin
               if (sof) begin
                  switching_q <= 1'b0;
                  hold_q      <= '0;
                  if (winValid) begin
                     sel_q   <= winIdx;
                     gnt_q   <= ONE_HOT0 << winIdx;
                     state_q <= GRANT;
                  end else begin
                     sel_q   <= '0;
                     gnt_q   <= ONE_HOT0;
                     state_q <= DEFAULT;
                  end
               end
            end
            default: begin
               state_q <= DEFAULT;
            end
         endcase
      end
   end

   assign gnt          = gnt_q;
   assign sel          = sel_q;
   assign switching    = switching_q;
   assign idle_timeout = timeout_q;
   assign pix_data     = src_data[sel_q*RGB565_W +: RGB565_W];

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Directed bench for lcd_frame_arbiter with hand-computed expectations.
module tb_lcd_frame_arbiter;

   logic        clk;
   logic        rst_n;
   logic        sof;
   logic [3:0]  req;
   logic [63:0] src_data;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic [15:0] pix_data;
   logic        switching;
   logic        idle_timeout;

   int checkCount;
   int passCount;

   lcd_frame_arbiter #(
      .N_SRC          (4),
      .MIN_HOLD       (2),
      .TIMEOUT_FRAMES (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sof          (sof),
      .req          (req),
      .src_data     (src_data),
      .gnt          (gnt),
      .sel          (sel),
      .pix_data     (pix_data),
      .switching    (switching),
      .idle_timeout (idle_timeout)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one clock cycle worth of inputs, then settle just after the edge.
   task automatic applyStimulus(input logic sofVal, input logic [3:0] reqVal);
      sof = sofVal;
      req = reqVal;
      @(posedge clk);
      #1;
      sof = 1'b0;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      sof        = 1'b0;
      req        = 4'b0000;
      src_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_sel",   sel,          0);
      checkOutput("rst_gnt",   gnt,          4'b0001);
      checkOutput("rst_sw",    switching,    0);
      checkOutput("rst_to",    idle_timeout, 0);
      rst_n = 1'b1;

      // Idle: three frames with no request stay on source 0.
      applyStimulus(1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'b0000);
         applyStimulus(1'b0, 4'b0000);
      end
      checkOutput("idle_sel", sel,          0);
      checkOutput("idle_gnt", gnt,          4'b0001);
      checkOutput("idle_pix", pix_data,     16'h1111);
      checkOutput("idle_sw",  switching,    0);
      checkOutput("idle_to3", idle_timeout, 0);

      // Fourth idle frame trips the timeout; a request clears it on the next edge.
      applyStimulus(1'b1, 4'b0000);
      checkOutput("idle_to4", idle_timeout, 1);
      applyStimulus(1'b0, 4'b0000);
      checkOutput("idle_to_hold", idle_timeout, 1);
      applyStimulus(1'b0, 4'b0010);
      checkOutput("to_clear", idle_timeout, 0);
      checkOutput("arm1_sw",  switching,    1);
      checkOutput("arm1_sel", sel,          0);
      applyStimulus(1'b1, 4'b0010);
      checkOutput("g1_sel", sel,       1);
      checkOutput("g1_gnt", gnt,       4'b0010);
      checkOutput("g1_pix", pix_data,  16'h2222);
      checkOutput("g1_sw",  switching, 0);

      // Higher priority must wait out the minimum hold.
      applyStimulus(1'b0, 4'b1010);
      checkOutput("hold_sw0", switching, 0);
      applyStimulus(1'b1, 4'b1010);
      checkOutput("hold_sof1_sel", sel, 1);
      applyStimulus(1'b0, 4'b1010);
      checkOutput("hold_sof1_sw", switching, 0);
      applyStimulus(1'b1, 4'b1010);
      checkOutput("hold_sof2_sel", sel, 1);
      applyStimulus(1'b0, 4'b1010);
      checkOutput("rel3_sw",  switching, 1);
      checkOutput("rel3_sel", sel,       1);
      applyStimulus(1'b1, 4'b1010);
      checkOutput("g3_sel", sel,       3);
      checkOutput("g3_gnt", gnt,       4'b1000);
      checkOutput("g3_pix", pix_data,  16'h4444);
      checkOutput("g3_sw",  switching, 0);

      // Dropping the granted request releases immediately, hold not required.
      applyStimulus(1'b0, 4'b0100);
      checkOutput("drop3_sw", switching, 1);
      applyStimulus(1'b1, 4'b0100);
      checkOutput("g2_sel", sel,      2);
      checkOutput("g2_pix", pix_data, 16'h3333);
      applyStimulus(1'b0, 4'b0000);
      checkOutput("drop2_sw",  switching, 1);
      checkOutput("drop2_sel", sel,       2);
      applyStimulus(1'b1, 4'b0000);
      checkOutput("def_sel", sel,       0);
      checkOutput("def_gnt", gnt,       4'b0001);
      checkOutput("def_sw",  switching, 0);

      // Mid-frame request for source 2: pending until the next frame start.
      applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b0, 4'b0100);
      checkOutput("mid_sw",  switching, 1);
      checkOutput("mid_sel", sel,       0);
      checkOutput("mid_pix", pix_data,  16'h1111);
      applyStimulus(1'b1, 4'b0100);
      checkOutput("mid_g_sel", sel,      2);
      checkOutput("mid_g_pix", pix_data, 16'h3333);
      applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b0, 4'b0100);
      checkOutput("mid_frame_sel", sel, 2);
      src_data[47:32] = 16'h5A5A;
      #1;
      checkOutput("pix_comb", pix_data, 16'h5A5A);
      src_data[47:32] = 16'h3333;

      // Back to default, then a higher request overtakes a pending one.
      applyStimulus(1'b0, 4'b0000);
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0010);
      applyStimulus(1'b0, 4'b1010);
      applyStimulus(1'b1, 4'b1010);
      checkOutput("overtake_sel", sel, 3);

      // A pending request that vanishes before the frame start returns to default.
      applyStimulus(1'b0, 4'b0000);
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b0, 4'b0000);
      checkOutput("cancel_sw", switching, 0);
      applyStimulus(1'b1, 4'b0000);
      checkOutput("cancel_sel", sel, 0);

      // Request coincident with a frame start in default waits one more frame.
      applyStimulus(1'b1, 4'b0010);
      checkOutput("coinc_sel", sel,       0);
      checkOutput("coinc_sw",  switching, 1);
      applyStimulus(1'b1, 4'b0010);
      checkOutput("coinc_g_sel", sel, 1);

      // Reset pulse while armed snaps the display back to source 0 at once.
      applyStimulus(1'b0, 4'b0000);
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b1000);
      checkOutput("pre_rst_sw", switching, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_sel", sel,       0);
      checkOutput("arst_gnt", gnt,       4'b0001);
      checkOutput("arst_sw",  switching, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 4'b1000);
      checkOutput("post_rst_sof1_sel", sel,       0);
      checkOutput("post_rst_sof1_sw",  switching, 1);
      applyStimulus(1'b1, 4'b1000);
      checkOutput("post_rst_sof2_sel", sel,      3);
      checkOutput("post_rst_sof2_pix", pix_data, 16'h4444);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
